// File: rtl/clause_status_scanner.sv
// Scans a snapshot of the clause assignment bus a group of clauses per cycle.
// Reports the satisfied count, all-satisfied, the first conflict and the first unit clause.
module clause_status_scanner #(
    parameter int NUM_CLAUSES         = 16,
    parameter int NUM_VARS_PER_CLAUSE = 3,
    parameter int CLAUSES_PER_CYCLE   = 4,
    localparam int IW = $clog2(NUM_CLAUSES),
    localparam int LW = (NUM_VARS_PER_CLAUSE > 1) ? $clog2(NUM_VARS_PER_CLAUSE) : 1,
    localparam int CW = $clog2(NUM_CLAUSES + 1)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_VARS_PER_CLAUSE*NUM_CLAUSES-1:0]  clause_values,
    input  logic [NUM_VARS_PER_CLAUSE*NUM_CLAUSES-1:0]  clause_assigned,
    input  logic                                        start,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        all_sat,
    output logic                                        conflict,
    output logic [IW-1:0]                               conflict_idx,
    output logic                                        unit_found,
    output logic [IW-1:0]                               unit_idx,
    output logic [LW-1:0]                               unit_lit,
    output logic [CW-1:0]                               sat_count
);

    localparam int NV  = NUM_VARS_PER_CLAUSE;
    localparam int NC  = NUM_CLAUSES;
    localparam int CPC = CLAUSES_PER_CYCLE;
    localparam int G   = NC / CPC;
    localparam int GW  = (G > 1) ? $clog2(G) : 1;
    localparam int GB  = CPC * NV;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state;
    logic [GW-1:0]    group;
    logic [NC*NV-1:0] snap_val;
    logic [NC*NV-1:0] snap_asg;

    logic [GB-1:0]    grp_val;
    logic [GB-1:0]    grp_asg;

    logic [NV-1:0]    cv;
    logic [NV-1:0]    ca;
    logic             csat;
    logic [LW:0]      nun;
    logic [LW-1:0]    upos;
    int               base;

    logic [CW-1:0]    grp_sat;
    logic             grp_conf;
    logic [IW-1:0]    grp_conf_idx;
    logic             grp_unit;
    logic [IW-1:0]    grp_unit_idx;
    logic [LW-1:0]    grp_unit_lit;

    logic [CW-1:0]    sat_next;

    assign grp_val  = snap_val[int'(group)*GB +: GB];
    assign grp_asg  = snap_asg[int'(group)*GB +: GB];
    assign sat_next = sat_count + grp_sat;

    // Classify every clause of the current group; the first hit wins for conflict and unit.
    always_comb begin
        cv           = '0;
        ca           = '0;
        csat         = 1'b0;
        nun          = '0;
        upos         = '0;
        base         = int'(group) * CPC;
        grp_sat      = '0;
        grp_conf     = 1'b0;
        grp_conf_idx = '0;
        grp_unit     = 1'b0;
        grp_unit_idx = '0;
        grp_unit_lit = '0;
        for (int i = 0; i < CPC; i++) begin
            cv   = grp_val[i*NV +: NV];
            ca   = grp_asg[i*NV +: NV];
            csat = |(cv & ca);
            nun  = '0;
            upos = '0;
            for (int l = 0; l < NV; l++) begin
                if (!ca[l]) begin
                    nun  = nun + {{LW{1'b0}}, 1'b1};
                    upos = LW'(l);
                end
            end
            if (csat) begin
                grp_sat = grp_sat + CW'(1);
            end
            if (!csat && (&ca) && !grp_conf) begin
                grp_conf     = 1'b1;
                grp_conf_idx = IW'(base + i);
            end
            if (!csat && (nun == {{LW{1'b0}}, 1'b1}) && !grp_unit) begin
                grp_unit     = 1'b1;
                grp_unit_idx = IW'(base + i);
                grp_unit_lit = upos;
            end
        end
    end

    // Pass sequencer; results accumulate during SCAN and hold until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            group        <= '0;
            snap_val     <= '0;
            snap_asg     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            all_sat      <= 1'b0;
            conflict     <= 1'b0;
            conflict_idx <= '0;
            unit_found   <= 1'b0;
            unit_idx     <= '0;
            unit_lit     <= '0;
            sat_count    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                SCAN: begin
                    sat_count <= sat_next;
                    if (!conflict && grp_conf) begin
                        conflict     <= 1'b1;
                        conflict_idx <= grp_conf_idx;
                    end
                    if (!unit_found && grp_unit) begin
                        unit_found <= 1'b1;
                        unit_idx   <= grp_unit_idx;
                        unit_lit   <= grp_unit_lit;
                    end
                    if (grp_conf || (group == GW'(G - 1))) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        all_sat <= (sat_next == CW'(NC)) && !conflict && !grp_conf;
                    end else begin
                        group <= group + GW'(1);
                    end
                end
                default: begin
                    if (start) begin
                        state        <= SCAN;
                        busy         <= 1'b1;
                        group        <= '0;
                        snap_val     <= clause_values;
                        snap_asg     <= clause_assigned;
                        all_sat      <= 1'b0;
                        conflict     <= 1'b0;
                        conflict_idx <= '0;
                        unit_found   <= 1'b0;
                        unit_idx     <= '0;
                        unit_lit     <= '0;
                        sat_count    <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clause_status_scanner.sv
// Randomized and directed bench for clause_status_scanner with a clause-level reference model.
module tb_clause_status_scanner;

    localparam int NV  = 3;
    localparam int NC  = 16;
    localparam int CPC = 4;
    localparam int G   = NC / CPC;
    localparam int NB  = NV * NC;

    typedef struct packed {
        logic [5:0] cyc;
        logic [5:0] busy_cycles;
        logic [3:0] extra;
        logic [4:0] sat_count;
        logic       all_sat;
        logic       conflict;
        logic [3:0] conflict_idx;
        logic       unit_found;
        logic [3:0] unit_idx;
        logic [1:0] unit_lit;
    } res_t;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] clause_values;
    logic [NB-1:0] clause_assigned;
    logic          start;
    logic          busy;
    logic          done;
    logic          all_sat;
    logic          conflict;
    logic [3:0]    conflict_idx;
    logic          unit_found;
    logic [3:0]    unit_idx;
    logic [1:0]    unit_lit;
    logic [4:0]    sat_count;

    int errors = 0;
    int checks = 0;

    clause_status_scanner #(
        .NUM_CLAUSES(NC),
        .NUM_VARS_PER_CLAUSE(NV),
        .CLAUSES_PER_CYCLE(CPC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clause_values(clause_values),
        .clause_assigned(clause_assigned),
        .start(start),
        .busy(busy),
        .done(done),
        .all_sat(all_sat),
        .conflict(conflict),
        .conflict_idx(conflict_idx),
        .unit_found(unit_found),
        .unit_idx(unit_idx),
        .unit_lit(unit_lit),
        .sat_count(sat_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic string fmt(res_t r);
        return $sformatf("cyc=%0d busy=%0d extra=%0d sat=%0d all=%0b conf=%0b cidx=%0d unit=%0b uidx=%0d ulit=%0d",
                         r.cyc, r.busy_cycles, r.extra, r.sat_count, r.all_sat, r.conflict,
                         r.conflict_idx, r.unit_found, r.unit_idx, r.unit_lit);
    endfunction

    // Reference: classify each clause from its literals, walk groups in order, stop after a conflicting group.
    function automatic res_t model(logic [NB-1:0] v, logic [NB-1:0] a);
        res_t r;
        int   cnt;
        int   c;
        int   ntrue;
        int   nunasg;
        int   pos;
        bit   stop;
        bit   gconf;
        r     = '0;
        cnt   = 0;
        stop  = 0;
        r.cyc = 6'(G + 1);
        for (int g = 0; g < G; g++) begin
            if (!stop) begin
                gconf = 0;
                for (int j = 0; j < CPC; j++) begin
                    c      = g * CPC + j;
                    ntrue  = 0;
                    nunasg = 0;
                    pos    = 0;
                    for (int l = 0; l < NV; l++) begin
                        if (a[c*NV + l]) begin
                            if (v[c*NV + l]) ntrue++;
                        end else begin
                            nunasg++;
                            pos = l;
                        end
                    end
                    if (ntrue > 0) begin
                        cnt++;
                    end else if (nunasg == 0) begin
                        gconf = 1;
                        if (!r.conflict) begin
                            r.conflict     = 1'b1;
                            r.conflict_idx = 4'(c);
                        end
                    end else if (nunasg == 1 && !r.unit_found) begin
                        r.unit_found = 1'b1;
                        r.unit_idx   = 4'(c);
                        r.unit_lit   = 2'(pos);
                    end
                end
                if (gconf) begin
                    stop  = 1;
                    r.cyc = 6'(g + 2);
                end
            end
        end
        r.sat_count   = 5'(cnt);
        r.all_sat     = (cnt == NC) && !r.conflict;
        r.busy_cycles = r.cyc - 6'd1;
        return r;
    endfunction

    function automatic logic [NB-1:0] rnd_mask(int pct);
        logic [NB-1:0] m;
        m = '0;
        for (int b = 0; b < NB; b++) m[b] = ($urandom_range(99) < pct);
        return m;
    endfunction

    function automatic logic [NB-1:0] all_lit0();
        logic [NB-1:0] m;
        m = '0;
        for (int c = 0; c < NC; c++) m[c*NV] = 1'b1;
        return m;
    endfunction

    // Drive one pass from IDLE and collect what the DUT reports; optionally disturb inputs mid-scan.
    task automatic run_pass(input logic [NB-1:0] v, input logic [NB-1:0] a, input bit perturb, output res_t obs);
        obs             = '0;
        clause_values   = v;
        clause_assigned = a;
        start           = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (perturb && k == 1) begin
                clause_values   = ~v;
                clause_assigned = ~a;
            end
            if (perturb && k == 2) start = 1'b1;
            if (perturb && k == 4) start = 1'b0;
            if (busy) obs.busy_cycles = obs.busy_cycles + 6'd1;
            if (done) begin
                if (obs.cyc == 0) begin
                    obs.cyc          = 6'(k);
                    obs.sat_count    = sat_count;
                    obs.all_sat      = all_sat;
                    obs.conflict     = conflict;
                    obs.conflict_idx = conflict_idx;
                    obs.unit_found   = unit_found;
                    obs.unit_idx     = unit_idx;
                    obs.unit_lit     = unit_lit;
                end else begin
                    obs.extra = obs.extra + 4'd1;
                end
            end
            if (obs.cyc != 0 && k >= int'(obs.cyc) + 3) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, all_sat, conflict, conflict_idx, unit_found, unit_idx, unit_lit, sat_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_asserted: got busy=%0b done=%0b sat=%0d conf=%0b required all zero",
                     busy, done, sat_count, conflict);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, all_sat, conflict, conflict_idx, unit_found, unit_idx, unit_lit, sat_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_released_idle: got busy=%0b done=%0b sat=%0d conf=%0b required all zero",
                     busy, done, sat_count, conflict);
        end
    endtask

    task automatic test_all_sat();
        res_t obs, exp;
        logic [NB-1:0] m;
        m   = all_lit0();
        exp = model(m, m);
        run_pass(m, m, 1'b0, obs);
        checks++;
        if (obs !== exp || exp.cyc != 6'd5 || exp.sat_count != 5'd16 || !exp.all_sat) begin
            errors++;
            $display("[TB] FAIL all_sat_pass: got %s required %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_conflict();
        res_t obs, exp;
        logic [NB-1:0] v, a;
        v = all_lit0();
        a = all_lit0();
        v[9*NV +: NV]  = 3'b000;
        a[9*NV +: NV]  = 3'b111;
        v[14*NV +: NV] = 3'b000;
        a[14*NV +: NV] = 3'b111;
        exp = model(v, a);
        run_pass(v, a, 1'b0, obs);
        checks++;
        if (obs !== exp || exp.cyc != 6'd4 || exp.conflict_idx != 4'd9) begin
            errors++;
            $display("[TB] FAIL conflict_early_stop: got %s required %s", fmt(obs), fmt(exp));
        end
    endtask

    function automatic void unit_data(output logic [NB-1:0] v, output logic [NB-1:0] a);
        v = all_lit0();
        a = all_lit0();
        v[5*NV +: NV]  = 3'b000;
        a[5*NV +: NV]  = 3'b011;
        v[12*NV +: NV] = 3'b000;
        a[12*NV +: NV] = 3'b110;
    endfunction

    task automatic test_unit();
        res_t obs, exp;
        logic [NB-1:0] v, a;
        unit_data(v, a);
        exp = model(v, a);
        run_pass(v, a, 1'b0, obs);
        checks++;
        if (obs !== exp || exp.unit_idx != 4'd5 || exp.unit_lit != 2'd2 || exp.sat_count != 5'd14) begin
            errors++;
            $display("[TB] FAIL unit_detect: got %s required %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_start_ignored();
        res_t obs, exp;
        logic [NB-1:0] v, a;
        unit_data(v, a);
        exp = model(v, a);
        run_pass(v, a, 1'b1, obs);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL start_ignored_snapshot: got %s required %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_reset_mid_scan();
        res_t obs, exp;
        logic [NB-1:0] m;
        int ndone;
        m               = all_lit0();
        clause_values   = m;
        clause_assigned = m;
        start           = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, all_sat, conflict, conflict_idx, unit_found, unit_idx, unit_lit, sat_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_scan_clear: got busy=%0b done=%0b sat=%0d required all zero",
                     busy, done, sat_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_scan_no_done: got %0d active cycles required 0", ndone);
        end
        exp = model(m, m);
        run_pass(m, m, 1'b0, obs);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL pass_after_reset: got %s required %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] dv [3];
        logic [NB-1:0] da [3];
        res_t obs, exp;
        int   idx, base, nbusy, extra;
        dv[0] = all_lit0();
        da[0] = all_lit0();
        unit_data(dv[1], da[1]);
        dv[2] = rnd_mask(50);
        da[2] = rnd_mask(60);
        for (int c = 0; c < NC; c++) begin
            if (&da[2][c*NV +: NV] && !(|(dv[2][c*NV +: NV] & da[2][c*NV +: NV]))) da[2][c*NV + 1] = 1'b0;
        end
        idx             = 0;
        base            = 0;
        nbusy           = 0;
        extra           = 0;
        clause_values   = dv[0];
        clause_assigned = da[0];
        start           = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 25; k++) begin
            if (busy) nbusy++;
            if (done) begin
                if (idx < 3) begin
                    exp              = model(dv[idx], da[idx]);
                    obs              = '0;
                    obs.cyc          = 6'(k - base);
                    obs.busy_cycles  = 6'(nbusy);
                    obs.sat_count    = sat_count;
                    obs.all_sat      = all_sat;
                    obs.conflict     = conflict;
                    obs.conflict_idx = conflict_idx;
                    obs.unit_found   = unit_found;
                    obs.unit_idx     = unit_idx;
                    obs.unit_lit     = unit_lit;
                    checks++;
                    if (obs !== exp || k != 5 * (idx + 1)) begin
                        errors++;
                        $display("[TB] FAIL back_to_back_pass%0d: at cycle %0d got %s required cycle %0d %s",
                                 idx, k, fmt(obs), 5 * (idx + 1), fmt(exp));
                    end
                    base  = k;
                    nbusy = 0;
                    idx++;
                    if (idx < 3) begin
                        clause_values   = dv[idx];
                        clause_assigned = da[idx];
                    end else begin
                        start = 1'b0;
                    end
                end else begin
                    extra++;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (idx != 3 || extra != 0) begin
            errors++;
            $display("[TB] FAIL back_to_back_count: got %0d passes and %0d extra done required 3 and 0", idx, extra);
        end
    endtask

    task automatic test_random();
        res_t obs, exp;
        logic [NB-1:0] v, a;
        for (int n = 0; n < 16; n++) begin
            v   = rnd_mask(50);
            a   = rnd_mask((n < 8) ? 65 : 85);
            exp = model(v, a);
            run_pass(v, a, 1'b0, obs);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL random_pass%0d: got %s required %s", n, fmt(obs), fmt(exp));
            end
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        clause_values   = '0;
        clause_assigned = '0;
        #2;
        test_reset();
        test_all_sat();
        test_conflict();
        test_unit();
        test_start_ignored();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
